// File: rtl/serial_shifter.sv
// Iterative WIDTH-bit shift unit (SLL/SRL/SRA/ROTL) moving one bit position per clock.
// Started by a start pulse in IDLE; reports completion with a single-cycle done pulse.
module serial_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5     // 2**SHW must equal WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] num,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]     OP_SLL  = 2'b00;
    localparam logic [1:0]     OP_SRL  = 2'b01;
    localparam logic [1:0]     OP_SRA  = 2'b10;
    localparam logic [1:0]     OP_ROTL = 2'b11;
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
    localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);

    state_t           state_r;
    logic [WIDTH-1:0] result_r;
    logic [SHW-1:0]   count_r;
    logic [1:0]       op_r;

    // One single-bit shift stage for the captured operation.
    function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] op_v,
                                                    input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] s;
        case (op_v)
            OP_SLL:  s = {r[WIDTH-2:0], 1'b0};
            OP_SRL:  s = {1'b0, r[WIDTH-1:1]};
            OP_SRA:  s = {r[WIDTH-1], r[WIDTH-1:1]};
            OP_ROTL: s = {r[WIDTH-2:0], r[WIDTH-1]};
            default: s = r;
        endcase
        return s;
    endfunction

    // Control FSM and datapath registers: accept, step once per cycle, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            result_r <= {WIDTH{1'b0}};
            count_r  <= CNT_ZERO;
            op_r     <= OP_SLL;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        result_r <= num;
                        op_r     <= op;
                        count_r  <= shamt;
                        state_r  <= (shamt != CNT_ZERO) ? ST_SHIFT : ST_DONE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    result_r <= shift_step(op_r, result_r);
                    count_r  <= count_r - CNT_ONE;
                    // count is at least one here, so the decrement never wraps
                    state_r  <= (count_r == CNT_ONE) ? ST_DONE : ST_SHIFT;
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign result = result_r;
    assign busy   = (state_r == ST_SHIFT) || (state_r == ST_DONE);
    assign done   = (state_r == ST_DONE);

endmodule
